// File: rtl/sram_pattern_seq.sv
// Pattern write / readback sequencer feeding sramtest.
// Readback and compare are built only with SRAM_PATTERN_SEQ_READBACK_EN.
module sram_pattern_seq #(
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int WMASK_WIDTH = 2,
  parameter int RD_LAT      = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  pattern,
  input  logic [1:0]             mode,
  input  logic [ADDR_WIDTH-1:0]  first_addr,
  input  logic [ADDR_WIDTH-1:0]  last_addr,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    err_count,
  output logic [ADDR_WIDTH-1:0]  first_err_addr,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
`ifdef SRAM_PATTERN_SEQ_READBACK_EN
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
`endif
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]            state;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] pat_q;
  logic [ADDR_WIDTH-1:0] span_q;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] nxt_addr;
`ifdef SRAM_PATTERN_SEQ_READBACK_EN
  logic [ADDR_WIDTH-1:0] first_q;
`endif

  function automatic logic [DATA_WIDTH-1:0] exp_word(
    input logic [1:0]            m,
    input logic [DATA_WIDTH-1:0] p,
    input logic                  odd,
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [DATA_WIDTH+ADDR_WIDTH-1:0] ext;
    ext = {{DATA_WIDTH{1'b0}}, a};
    case (m)
      2'd1:    return odd ? ~p : p;
      2'd2:    return p ^ ext[DATA_WIDTH-1:0];
      default: return p;
    endcase
  endfunction

  assign nxt_addr = sram_addr + 1'b1;
  assign busy     = (state != S_IDLE);

  // Sequencer FSM and registered SRAM-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      mode_q     <= '0;
      pat_q      <= '0;
      span_q     <= '0;
      cnt        <= '0;
      done       <= 1'b0;
      sram_we    <= 1'b0;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
`ifdef SRAM_PATTERN_SEQ_READBACK_EN
      first_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            pat_q      <= pattern;
            span_q     <= last_addr - first_addr;
            cnt        <= '0;
            sram_we    <= 1'b1;
            sram_wmask <= '1;
            sram_addr  <= first_addr;
            sram_din   <= exp_word(mode, pattern, 1'b0, first_addr);
            state      <= S_WRITE;
`ifdef SRAM_PATTERN_SEQ_READBACK_EN
            first_q    <= first_addr;
`endif
          end
        end
        S_WRITE: begin
          if (cnt == span_q) begin
            sram_we    <= 1'b0;
            sram_wmask <= '0;
`ifdef SRAM_PATTERN_SEQ_READBACK_EN
            state      <= S_GAP;
`else
            state      <= S_DONE;
            done       <= 1'b1;
`endif
          end else begin
            cnt       <= cnt + 1'b1;
            sram_addr <= nxt_addr;
            sram_din  <= exp_word(mode_q, pat_q, ~cnt[0], nxt_addr);
          end
        end
`ifdef SRAM_PATTERN_SEQ_READBACK_EN
        S_GAP: begin
          state     <= S_READ;
          cnt       <= '0;
          sram_addr <= first_q;
        end
        S_READ: begin
          if (cnt == span_q) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt       <= cnt + 1'b1;
            sram_addr <= nxt_addr;
          end
        end
        S_DRAIN: begin
          if (cnt == ADDR_WIDTH'(RD_LAT - 1)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SRAM_PATTERN_SEQ_READBACK_EN
  logic                  pv [RD_LAT];
  logic [ADDR_WIDTH-1:0] pa [RD_LAT];
  logic [DATA_WIDTH-1:0] pe [RD_LAT];
  logic                  hit;

  assign hit = pv[RD_LAT-1] && (pe[RD_LAT-1] != sram_dout);

  // Read-tracking pipeline aligned to the SRAM read latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pe[i] <= '0;
      end
    end else begin
      pv[0] <= (state == S_READ);
      pa[0] <= sram_addr;
      pe[0] <= exp_word(mode_q, pat_q, cnt[0], sram_addr);
      for (int i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  // Mismatch counter and first failing address, cleared by start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (state == S_IDLE && start) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (hit) begin
      err_count <= err_count + 1'b1;
      if (err_count == '0) first_err_addr <= pa[RD_LAT-1];
    end
  end
`else
  logic unused_rd;
  assign unused_rd      = ^{sram_dout, 1'(RD_LAT)};
  assign err_count      = '0;
  assign first_err_addr = '0;
`endif

endmodule
